// File: rtl/enc8b10b_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | enc8b10b_pkg : symbol width, K28.5 comma variants, RD encoding, popcount  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package enc8b10b_pkg;

  localparam int SYM_W = 10;
  localparam int CNT_W = 4;

  typedef logic [SYM_W-1:0] sym_t;

  // K28.5 variants shared with the encoder: NEG is sent at RD-, POS at RD+.
  localparam sym_t K28_5_NEG = 10'b0011111010;
  localparam sym_t K28_5_POS = 10'b1100000101;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  localparam logic [CNT_W-1:0] LAST_BIT = 4'd9;

  function automatic logic [CNT_W-1:0] popcount(input sym_t w);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < SYM_W; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, w[i]};
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/disparity_calc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disparity_calc : running-disparity update and legality of a 10b word      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module disparity_calc
  import enc8b10b_pkg::*;
(
  input  sym_t i_word,
  input  logic i_rd,
  output logic o_rd,
  output logic o_illegal
);

  logic [CNT_W-1:0] w_ones;

  assign w_ones = popcount(i_word);

  always_comb begin
    o_rd      = i_rd;
    o_illegal = 1'b0;
    if (w_ones == 4'd5) begin
      o_rd      = i_rd;
      o_illegal = 1'b0;
    end else if (w_ones == 4'd6) begin
      o_rd      = RD_POS;
      o_illegal = (i_rd != RD_NEG);
    end else if (w_ones == 4'd4) begin
      o_rd      = RD_NEG;
      o_illegal = (i_rd != RD_POS);
    end else begin
      // Unbalanced words still steer RD toward their dominant polarity.
      o_rd      = (w_ones > 4'd5) ? RD_POS : RD_NEG;
      o_illegal = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_serializer_10b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_serializer_10b : 10b symbol serializer with K28.5 idle insertion       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tx_serializer_10b
  import enc8b10b_pkg::*;
#(
  parameter sym_t COMMA_NEG = K28_5_NEG,
  parameter sym_t COMMA_POS = K28_5_POS
) (
  input  logic             INTERCLK,
  input  logic             Reset,
  input  logic [SYM_W-1:0] iSymbol,
  input  logic             iValid,
  output logic             oReady,
  output logic             oSerial,
  output logic             oSymStart,
  output logic             oIdle,
  output logic             oRdPos,
  output logic             oDispErr
);

  sym_t             r_shreg;
  logic [CNT_W-1:0] r_bitcnt;
  logic             r_rd;
  logic             r_idle;
  logic             r_err;

  logic             w_last;
  sym_t             w_comma;
  sym_t             w_next_word;
  logic             w_rd_next;
  logic             w_illegal;
  logic [CNT_W-1:0] w_bitidx;

  assign w_last      = (r_bitcnt == LAST_BIT);
  assign w_comma     = (r_rd == RD_POS) ? COMMA_POS : COMMA_NEG;
  assign w_next_word = iValid ? sym_t'(iSymbol) : w_comma;

  disparity_calc u_disparity_calc (
    .i_word    (w_next_word),
    .i_rd      (r_rd),
    .o_rd      (w_rd_next),
    .o_illegal (w_illegal)
  );

  // Every edge advances the bit counter; the word boundary is also the load.
  always_ff @(posedge INTERCLK or negedge Reset) begin
    if (!Reset) begin
      r_shreg  <= COMMA_NEG;
      r_bitcnt <= '0;
      r_rd     <= RD_POS;
      r_idle   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_bitcnt <= w_last ? '0 : r_bitcnt + 4'd1;
      if (w_last) begin
        r_shreg <= w_next_word;
        r_idle  <= ~iValid;
        r_rd    <= w_rd_next;
        r_err   <= iValid & w_illegal;
      end
    end
  end

  // Bit 'a' (MSB) goes out first.
  assign w_bitidx  = LAST_BIT - r_bitcnt;
  assign oSerial   = r_shreg[w_bitidx];
  assign oSymStart = (r_bitcnt == '0);
  assign oReady    = w_last;
  assign oIdle     = r_idle;
  assign oRdPos    = r_rd;
  assign oDispErr  = r_err & (r_bitcnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_tx_serializer_10b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tx_serializer_10b : vector table, corner sequences, random vs model    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_tx_serializer_10b;

  localparam logic [9:0] NEG = 10'b0011111010;
  localparam logic [9:0] POS = 10'b1100000101;
  localparam int         NV  = 18;

  logic       INTERCLK = 1'b0;
  logic       Reset;
  logic [9:0] iSymbol;
  logic       iValid;
  logic       oReady, oSerial, oSymStart, oIdle, oRdPos, oDispErr;

  int n_checks = 0;
  int n_errors = 0;

  tx_serializer_10b dut (
    .INTERCLK  (INTERCLK),
    .Reset     (Reset),
    .iSymbol   (iSymbol),
    .iValid    (iValid),
    .oReady    (oReady),
    .oSerial   (oSerial),
    .oSymStart (oSymStart),
    .oIdle     (oIdle),
    .oRdPos    (oRdPos),
    .oDispErr  (oDispErr)
  );

  always #5 INTERCLK = ~INTERCLK;

  function automatic logic [5:0] outs();
    return {oSerial, oSymStart, oReady, oIdle, oRdPos, oDispErr};
  endfunction

  task automatic chk6(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk10(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference model: a queue of expected per-cycle outputs, one entry per bit.
  typedef struct packed {
    logic ser;
    logic start;
    logic ready;
    logic idle;
    logic rdpos;
    logic err;
  } exp_t;

  exp_t q[$];
  logic m_rd;
  logic m_last;
  bit   model_on = 0;

  function automatic void model_push(input logic v, input logic [9:0] s);
    logic [9:0] w;
    int         n;
    logic       legal;
    logic       nrd;
    exp_t       e;
    w     = v ? s : (m_rd ? POS : NEG);
    n     = $countones(w);
    legal = (n == 5) || (n == 6 && !m_rd) || (n == 4 && m_rd);
    nrd   = (n == 5) ? m_rd : (n > 5);
    for (int i = 0; i < 10; i++) begin
      e.ser   = w[9-i];
      e.start = (i == 0);
      e.ready = (i == 9);
      e.idle  = !v;
      e.rdpos = nrd;
      e.err   = (i == 0) && !legal;
      q.push_back(e);
    end
    m_rd = nrd;
  endfunction

  function automatic void model_reset();
    exp_t e;
    q.delete();
    m_rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e.ser   = NEG[9-i];
      e.start = (i == 0);
      e.ready = (i == 9);
      e.idle  = 1'b1;
      e.rdpos = 1'b1;
      e.err   = 1'b0;
      q.push_back(e);
    end
  endfunction

  always @(negedge INTERCLK) begin
    if (model_on && Reset) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL model_empty: got empty queue expected an entry");
      end else begin
        chk6("model", outs(), q[0]);
      end
    end
  end

  always @(posedge INTERCLK) begin
    if (model_on && Reset && q.size() > 0) begin
      m_last = q[0].ready;
      void'(q.pop_front());
      if (m_last) model_push(iValid, iSymbol);
    end
  end

  task automatic wait_accept(input string nm);
    bit acc = 1'b0;
    int n   = 0;
    while (!acc && n < 25) begin
      @(negedge INTERCLK);
      acc = oReady;
      @(posedge INTERCLK);
      #1;
      n++;
    end
    n_checks++;
    if (!acc) begin
      n_errors++;
      $display("FAIL %s: got no accept in %0d cycles expected accept within 25", nm, n);
    end
  endtask

  task automatic collect_word(output logic [9:0] w);
    for (int c = 0; c < 10; c++) begin
      @(negedge INTERCLK);
      w[9-c] = oSerial;
      @(posedge INTERCLK);
      #1;
    end
  endtask

  typedef struct {
    logic       valid;
    logic [9:0] sym;
    logic [9:0] word;
    logic       idle;
    logic       rd;
    logic       err;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [9:0] s, input logic [9:0] w,
                              input logic idle, input logic rd, input logic err);
    vec_t t;
    t.valid = v; t.sym = s; t.word = w; t.idle = idle; t.rd = rd; t.err = err;
    return t;
  endfunction

  vec_t tbl[NV];

  initial begin
    vec_t       e;
    logic [9:0] got;
    logic [9:0] held;

    // Each row: what is offered at a load, and the word/flags that load produces.
    tbl[0]  = mk(1'b0, 10'b0,          POS,           1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 10'b0,          NEG,           1'b1, 1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 10'b1010101010, 10'b1010101010, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 10'b1001110100, 10'b1001110100, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b1, 10'b0011111010, 10'b0011111010, 1'b0, 1'b1, 1'b1);
    tbl[5]  = mk(1'b0, 10'b0,          POS,           1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 10'b1111111111, 10'b1111111111, 1'b0, 1'b1, 1'b1);
    tbl[7]  = mk(1'b1, 10'b0101010100, 10'b0101010100, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 10'b0000011111, 10'b0000011111, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 10'b0000000000, 10'b0000000000, 1'b0, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 10'b1110101000, 10'b1110101000, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 10'b1110101100, 10'b1110101100, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(1'b1, 10'b0001011010, 10'b0001011010, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 10'b0001011010, 10'b0001011010, 1'b0, 1'b0, 1'b1);
    tbl[14] = mk(1'b0, 10'b0,          NEG,           1'b1, 1'b1, 1'b0);
    tbl[15] = mk(1'b1, 10'b1111100000, 10'b1111100000, 1'b0, 1'b1, 1'b0);
    tbl[16] = mk(1'b1, 10'b1001110100, 10'b1001110100, 1'b0, 1'b1, 1'b0);
    tbl[17] = mk(1'b1, 10'b1001110100, 10'b1001110100, 1'b0, 1'b1, 1'b0);

    Reset   = 1'b0;
    iValid  = 1'b0;
    iSymbol = '0;
    repeat (3) @(posedge INTERCLK);
    #1;
    chk6("reset_state", outs(), 6'b010110);
    model_reset();
    model_on = 1;
    Reset    = 1'b1;

    // Table phase: row j is offered while the word from row j-1 is on the line.
    for (int j = 0; j <= NV; j++) begin
      if (j < NV) begin
        iValid  = tbl[j].valid;
        iSymbol = tbl[j].sym;
      end else begin
        iValid  = 1'b0;
        iSymbol = '0;
      end
      if (j == 0) e = mk(1'b0, 10'b0, NEG, 1'b1, 1'b1, 1'b0);
      else        e = tbl[j-1];
      for (int c = 0; c < 10; c++) begin
        @(negedge INTERCLK);
        got[9-c] = oSerial;
        chk6($sformatf("tbl%0d_flags_c%0d", j, c),
             {1'b0, oSymStart, oReady, oIdle, oRdPos, oDispErr},
             {1'b0, c == 0, c == 9, e.idle, e.rd, e.err && (c == 0)});
        @(posedge INTERCLK);
        #1;
      end
      chk10($sformatf("tbl%0d_word", j), got, e.word);
    end

    // Reset in the middle of a data word, with the next symbol already held.
    iSymbol = 10'b1011010010;
    iValid  = 1'b1;
    wait_accept("accept_before_reset");
    held    = 10'b0110110001;
    iSymbol = held;
    repeat (4) @(posedge INTERCLK);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    chk6("async_reset", outs(), 6'b010110);
    repeat (2) @(posedge INTERCLK);
    #1;
    chk6("reset_hold", outs(), 6'b010110);
    Reset = 1'b1;
    collect_word(got);
    chk10("post_reset_comma", got, NEG);
    iValid = 1'b0;
    collect_word(got);
    chk10("held_symbol", got, held);

    // Random phase: handshake-respecting traffic with idle gaps.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        iValid = 1'b0;
        repeat ($urandom_range(1, 15)) @(posedge INTERCLK);
        #1;
      end else begin
        iSymbol = 10'($urandom);
        iValid  = 1'b1;
        wait_accept($sformatf("rand_accept%0d", k));
        iValid  = 1'b0;
      end
    end
    repeat (12) @(posedge INTERCLK);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_serializer_10b.md
Name: tx_serializer_10b

Overview:
- Parallel-to-serial stage directly downstream of the 8b/10b encoder.
- Accepts 10-bit encoded symbols over a valid/ready handshake and shifts them out one bit per INTERCLK cycle (bit clock domain).
- Inserts K28.5 comma idles of the correct running-disparity variant when no symbol is offered.
- Tracks running disparity (RD) and flags symbols whose disparity is illegal.

Parameters:
- COMMA_NEG, 10'b0011111010, K28.5 sent when current RD is negative (6 ones).
- COMMA_POS, 10'b1100000101, K28.5 sent when current RD is positive (4 ones).

Ports:
- INTERCLK  input  1  bit clock; all state on rising edge.
- Reset  input  1  asynchronous, active-low reset (Reset=0 resets).
- iSymbol  input  10  encoded symbol; bit 9 = 'a', transmitted first; bit 0 = 'j', transmitted last.
- iValid  input  1  iSymbol is valid.
- oReady  output  1  serializer accepts a symbol on this edge if iValid=1.
- oSerial  output  1  serial bit stream.
- oSymStart  output  1  high during the first bit (bit 'a') of every word.
- oIdle  output  1  high for all 10 bit cycles of an inserted comma.
- oRdPos  output  1  RD after the word currently being shifted (1 = positive).
- oDispErr  output  1  one-cycle pulse during the first bit of an illegal word.

Behaviour:
- State:
  - shreg[9:0]: current word.
  - bitcnt 0..9.
  - rd.
  - idle flag.
  - err flag.
- oSerial = shreg[9 - bitcnt], combinational from registers. oSymStart = (bitcnt==0). oReady = (bitcnt==9). All are glitch-free functions of registers.
- Reset asserted, asynchronously and mid-word included:
  - shreg=COMMA_NEG, bitcnt=0, rd=1, idle=1, err=0.
  - Resulting outputs: oSerial=0, oReady=0, oSymStart=1, oIdle=1, oRdPos=1, oDispErr=0.
  - Any partially shifted word is discarded. No symbol is accepted while Reset=0.
- bitcnt increments 0→9 every edge and wraps 9→0. No gaps between words.
- Load occurs on the edge where bitcnt==9:
  - If iValid=1: shreg←iSymbol, idle←0 (handshake transfer).
  - Else: shreg←(rd ? COMMA_POS : COMMA_NEG), idle←1.
  - iValid while oReady=0 is ignored. Upstream holds iSymbol/iValid until oReady.
- Latency: a symbol accepted at edge E has its bit 'a' on oSerial in the cycle after E. Its last bit appears 9 cycles later.
- RD update at load, using n = number of ones in the loaded word and old rd:
  - n=5: rd unchanged. Legal, except 10'b1111100000 / 10'b0000011111 are also legal; no run-length check.
  - n=6: legal only if old rd=0; rd←1.
  - n=4: legal only if old rd=1; rd←0.
  - n=6 with old rd=1, n=4 with old rd=0, or n∉{4,5,6}: illegal. err←1 for the next word period's first bit only. rd←(n>5) ? 1 : 0, or unchanged if n=5.
- oDispErr = err AND (bitcnt==0). err clears on the next non-error load.
- Inserted commas are always legal by construction and never raise oDispErr.
- Simultaneous events: reset overrides load. A load and the bitcnt wrap happen on the same edge.
- No backpressure beyond oReady. Overflow is impossible; underflow produces idles.

Decomposition:
- Shared package `enc8b10b_pkg`:
  - SYM_W=10.
  - K28_5_NEG / K28_5_POS constants, which the encoder shares.
  - Function or constant for the RD_NEG/RD_POS encoding.
- One sub-module, `disparity_calc`: combinational popcount of 10 bits. Inputs: word, old rd. Outputs: new rd, illegal flag. Reusable by an RX-side checker.
- Top holds the counter, shift register, and handshake. Target ~150–200 lines.

Test Plan:
- Reset, iValid=0 for 30 cycles → oSerial = 0011111010, 1100000101, 0011111010. oIdle=1 throughout. oRdPos sequence 1,0,1 (updated at each load). oDispErr=0.
- After reset, iSymbol=10'b1010101010 held with iValid=1 → accepted at the first bitcnt==9 edge. Next 10 bits are 1,0,1,0,1,0,1,0,1,0. oIdle=0, oRdPos unchanged (1). oReady high exactly 1 of every 10 cycles.
- Back-to-back D-symbols 10'b1001110100 (RD- variant of D0.0, 5 ones) continuously valid → no idle ever inserted, contiguous 10-bit periods, oSymStart every 10th cycle.
- With rd=1, send 10'b0011111010 (6 ones) → oDispErr pulses once at the word's first bit. oRdPos stays 1. The following idle is COMMA_POS.
- Send 10'b1111111111 → oDispErr pulse, oRdPos=1. A subsequent legal 4-ones word → oDispErr=0, oRdPos=0.
- Assert Reset at bitcnt=4 of a data word → outputs immediately take reset values (oSerial=0, oIdle=1). After release, COMMA_NEG is emitted from bit 'a'. The held iValid symbol is accepted at the next bitcnt==9.
